// File: rtl/shared_mem_arbiter.sv
// Two-port arbiter for a single-port synchronous RAM: data port D has fixed priority,
// and a starvation counter forces a fetch (F) grant after STARVE_MAX consecutive losses.
module shared_mem_arbiter #(
   parameter int ADDR_W     = 14,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_gnt,
   output logic              f_rvalid,
   output logic [31:0]       f_rdata,

   input  logic              d_req,
   input  logic              d_we,
   input  logic [3:0]        d_wmask,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,

   output logic              ram_en,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [3:0]        ram_wmask,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,

   output logic [31:0]       conflict_cnt
);

   logic [3:0] starve_cnt;
   logic       force_f;

   // F is forced through once it has lost STARVE_MAX conflicts in a row.
   assign force_f = (starve_cnt == 4'(STARVE_MAX));
   assign d_gnt   = d_req & ~(f_req & force_f);
   assign f_gnt   = f_req & ~d_gnt;
   assign ram_en  = f_gnt | d_gnt;

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      ram_addr  = f_addr;
      ram_wmask = 4'b0000;
      ram_wdata = 32'h0;
      if (d_gnt) begin
         ram_addr  = d_addr;
         ram_wdata = d_wdata;
         if (d_we) ram_wmask = d_wmask;
      end
   end

   // The RAM returns data one cycle after the access; each port qualifies it with its own valid.
   assign f_rdata = ram_rdata;
   assign d_rdata = ram_rdata;

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_cnt   <= 4'd0;
         f_rvalid     <= 1'b0;
         d_rvalid     <= 1'b0;
         conflict_cnt <= 32'd0;
      end else begin
         f_rvalid <= f_gnt;
         d_rvalid <= d_gnt & ~d_we;

         // Counts only consecutive losses; a fetch grant or an idle fetch port clears it.
         if (f_req & d_gnt) starve_cnt <= starve_cnt + 4'd1;
         else               starve_cnt <= 4'd0;

         if (f_req & d_req && conflict_cnt != 32'hFFFF_FFFF)
            conflict_cnt <= conflict_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter: behavioural RAM, expected read data queued at
// grant time and popped by an independent monitor when the DUT raises an rvalid.
module tb_shared_mem_arbiter;
   localparam int AW = 14;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [AW-1:0] f_addr = '0, d_addr = '0;
   logic [3:0]    d_wmask = 4'b0;
   logic [31:0]   d_wdata = 32'h0;
   logic          f_gnt, f_rvalid, d_gnt, d_rvalid, ram_en;
   logic [31:0]   f_rdata, d_rdata, ram_wdata, conflict_cnt;
   logic [31:0]   ram_rdata = 32'h0;
   logic [AW-1:0] ram_addr;
   logic [3:0]    ram_wmask;

   int total = 0;
   int bad   = 0;
   logic [31:0] fq[$];
   logic [31:0] dq[$];

   // Preload path into the behavioural RAM, used only while reset is held.
   logic          pl_en = 1'b0;
   logic [AW-1:0] pl_addr = '0;
   logic [31:0]   pl_data = 32'h0;
   logic [31:0]   mem [0:(1<<AW)-1];

   always #5 clk = ~clk;

   shared_mem_arbiter #(.ADDR_W(AW), .STARVE_MAX(4)) dut (
      .clk(clk), .reset(reset),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
      .d_req(d_req), .d_we(d_we), .d_wmask(d_wmask), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .ram_en(ram_en), .ram_addr(ram_addr), .ram_wmask(ram_wmask), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .conflict_cnt(conflict_cnt)
   );

   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (ram_en) begin
         if (ram_wmask == 4'b0000) ram_rdata <= mem[ram_addr];
         else for (int b = 0; b < 4; b++)
            if (ram_wmask[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   // Monitor: every rvalid must match the oldest queued expectation of that port.
   always @(negedge clk) begin
      if (!reset) begin
         if (f_rvalid) begin
            if (fq.size() == 0) check("f_rvalid_unexpected", 32'd1, 32'd0);
            else check("f_rdata", f_rdata, fq.pop_front());
         end
         if (d_rvalid) begin
            if (dq.size() == 0) check("d_rvalid_unexpected", 32'd1, 32'd0);
            else check("d_rdata", d_rdata, dq.pop_front());
         end
      end
   end

   logic [9:0] t2_f_exp;
   logic [8:0] t5_f_req, t5_f_exp;
   int i;

   initial begin
      t2_f_exp = 10'b10_0001_0000;
      t5_f_req = 9'b1_1111_0111;
      t5_f_exp = 9'b1_0000_0000;

      // Reset state with RAM preload underway
      preload(14'd5, 32'hDEADBEEF);
      preload(14'd10, 32'hA0A0A0A0);
      preload(14'd20, 32'hB0B0B0B0);
      preload(14'd3, 32'h11223344);
      check("rst_f_rvalid", {31'd0, f_rvalid}, 32'd0);
      check("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
      check("rst_conflict_cnt", conflict_cnt, 32'd0);
      check("idle_ram_en", {31'd0, ram_en}, 32'd0);
      reset = 1'b0;
      next_cycle();

      // 1: lone fetch read
      f_req = 1'b1; f_addr = 14'd5;
      @(negedge clk);
      check("t1_f_gnt", {31'd0, f_gnt}, 32'd1);
      check("t1_d_gnt", {31'd0, d_gnt}, 32'd0);
      check("t1_ram_addr", {18'd0, ram_addr}, 32'd5);
      check("t1_ram_wmask", {28'd0, ram_wmask}, 32'd0);
      check("t1_ram_wdata", ram_wdata, 32'd0);
      fq.push_back(32'hDEADBEEF);
      next_cycle();
      f_req = 1'b0;
      @(negedge clk);
      check("t1_f_rvalid", {31'd0, f_rvalid}, 32'd1);
      check("t1_d_rvalid", {31'd0, d_rvalid}, 32'd0);
      check("t1_idle_ram_en", {31'd0, ram_en}, 32'd0);
      next_cycle();

      // 2: ten conflict cycles, F forced on cycles 4 and 9
      f_req = 1'b1; f_addr = 14'd10; d_req = 1'b1; d_we = 1'b0; d_addr = 14'd20;
      for (i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("t2_f_gnt[%0d]", i), {31'd0, f_gnt}, {31'd0, t2_f_exp[i]});
         check($sformatf("t2_d_gnt[%0d]", i), {31'd0, d_gnt}, {31'd0, ~t2_f_exp[i]});
         if (t2_f_exp[i]) fq.push_back(32'hA0A0A0A0);
         else             dq.push_back(32'hB0B0B0B0);
         next_cycle();
      end
      f_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      check("t2_conflict_cnt", conflict_cnt, 32'd10);
      next_cycle();

      // 3: byte store then fetch of the same word
      d_req = 1'b1; d_we = 1'b1; d_addr = 14'd3; d_wmask = 4'b0010; d_wdata = 32'h0000AB00;
      @(negedge clk);
      check("t3_d_gnt", {31'd0, d_gnt}, 32'd1);
      check("t3_ram_wmask", {28'd0, ram_wmask}, 32'h2);
      check("t3_ram_wdata", ram_wdata, 32'h0000AB00);
      next_cycle();
      d_req = 1'b0; f_req = 1'b1; f_addr = 14'd3;
      @(negedge clk);
      check("t3_f_gnt", {31'd0, f_gnt}, 32'd1);
      check("t3_d_rvalid", {31'd0, d_rvalid}, 32'd0);
      fq.push_back(32'h1122AB44);
      next_cycle();
      f_req = 1'b0;
      next_cycle();

      // 4: store wins over a simultaneous fetch; fetch follows without a bubble
      d_req = 1'b1; d_we = 1'b1; d_addr = 14'd7; d_wmask = 4'b1111; d_wdata = 32'h55AA55AA;
      f_req = 1'b1; f_addr = 14'd7;
      @(negedge clk);
      check("t4_d_gnt", {31'd0, d_gnt}, 32'd1);
      check("t4_f_gnt", {31'd0, f_gnt}, 32'd0);
      check("t4_ram_wmask", {28'd0, ram_wmask}, 32'hF);
      next_cycle();
      d_req = 1'b0;
      @(negedge clk);
      check("t4_f_gnt_next", {31'd0, f_gnt}, 32'd1);
      check("t4_d_rvalid", {31'd0, d_rvalid}, 32'd0);
      fq.push_back(32'h55AA55AA);
      next_cycle();
      f_req = 1'b0; d_we = 1'b0; d_wmask = 4'b0;
      next_cycle();

      // 5: a one-cycle gap in fetch requests restarts the starvation count
      f_addr = 14'd10; d_addr = 14'd20; d_req = 1'b1;
      for (i = 0; i < 9; i++) begin
         f_req = t5_f_req[i];
         @(negedge clk);
         check($sformatf("t5_f_gnt[%0d]", i), {31'd0, f_gnt}, {31'd0, t5_f_exp[i]});
         check($sformatf("t5_d_gnt[%0d]", i), {31'd0, d_gnt}, {31'd0, ~t5_f_exp[i]});
         if (t5_f_exp[i]) fq.push_back(32'hA0A0A0A0);
         else             dq.push_back(32'hB0B0B0B0);
         next_cycle();
      end
      f_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      check("t5_conflict_cnt", conflict_cnt, 32'd19);
      next_cycle();

      // 6: reset right after a fetch grant drops the return in flight
      f_req = 1'b1; f_addr = 14'd5;
      @(negedge clk);
      check("t6_f_gnt", {31'd0, f_gnt}, 32'd1);
      next_cycle();
      f_req = 1'b0;
      #1 reset = 1'b1;
      #1;
      check("t6_rst_f_rvalid", {31'd0, f_rvalid}, 32'd0);
      check("t6_rst_conflict_cnt", conflict_cnt, 32'd0);
      #1 reset = 1'b0;
      @(negedge clk);
      check("t6_f_rvalid_after", {31'd0, f_rvalid}, 32'd0);
      next_cycle();
      f_req = 1'b1; f_addr = 14'd10; d_req = 1'b1; d_we = 1'b0; d_addr = 14'd20;
      @(negedge clk);
      check("t6_d_gnt", {31'd0, d_gnt}, 32'd1);
      check("t6_f_gnt_lose", {31'd0, f_gnt}, 32'd0);
      check("t6_f_rvalid_stays", {31'd0, f_rvalid}, 32'd0);
      dq.push_back(32'hB0B0B0B0);
      next_cycle();
      f_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      check("t6_conflict_cnt", conflict_cnt, 32'd1);
      next_cycle();
      next_cycle();

      check("fq_drained", fq.size(), 32'd0);
      check("dq_drained", dq.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
